cmp_stim_checker: RTL and testbench

//  Synthesizable self-checking driver for the WIDTH-bit magnitude comparator: generates

---
 rtl/cmp_pkg.sv | 29 ++
 rtl/cmp_stim_checker_if.sv | 15 +
 rtl/cmp_lfsr.sv | 43 ++++
 rtl/cmp_stim_checker.sv | 174 +++++++++++++++++
 tb/tb_cmp_stim_checker.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator stimulus checker.
//  - state_e      : checker FSM states
//  - LFSR_TAPS    : maximal-length right-shift Galois masks, indexed by LFSR width 4..16
//  - exp_flags()  : reference {gt,lt,eq} for an operand pair (operands zero-extended to 8 bits)
package cmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned MAX_OP_W = 8;
  localparam int unsigned CNT_W    = 8;

  // Mask bit (t-1) set for every feedback tap t of a primitive polynomial.
  localparam logic [15:0] LFSR_TAPS [4:16] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  function automatic logic [2:0] exp_flags(input logic [MAX_OP_W-1:0] a,
                                           input logic [MAX_OP_W-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

endpackage

// File: rtl/cmp_stim_checker_if.sv
// Operand/flag bundle between the stimulus checker and the comparator under test.
//  master : checker side (drives op_a/op_b, receives dut_gt/dut_lt/dut_eq)
//  slave  : comparator side
interface cmp_stim_checker_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             dut_gt;
  logic             dut_lt;
  logic             dut_eq;

  modport master (output op_a, output op_b, input dut_gt, input dut_lt, input dut_eq);
  modport slave  (input op_a, input op_b, output dut_gt, output dut_lt, output dut_eq);
endinterface

// File: rtl/cmp_lfsr.sv
// 2*WIDTH-bit Galois LFSR operand source.
//  clk, rst_n : clock, synchronous active-low reset (reset value = seed)
//  load_i     : reload seed (priority over step_i)
//  step_i     : advance one state
//  value_o    : current LFSR state
module cmp_lfsr
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter logic [15:0] SEED  = 16'h00A5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic [2*WIDTH-1:0]   value_o
);

  localparam int unsigned L = 2 * WIDTH;
  localparam logic [L-1:0] TAPS     = LFSR_TAPS[L][L-1:0];
  localparam logic [L-1:0] SEED_RAW = SEED[L-1:0];
  // An all-zero state would lock up the LFSR.
  localparam logic [L-1:0] SEED_L   = (SEED_RAW == '0) ? L'(1) : SEED_RAW;

  logic [L-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = SEED_L;
    end else if (step_i) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= SEED_L;
    else        value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/cmp_stim_checker.sv
// Self-checking stimulus driver for a WIDTH-bit magnitude comparator.
// Drives LFSR operand pairs, samples the comparator flags LAT+1 cycles later and
// counts mismatches against exp_flags().
//  clk, rst_n : clock, synchronous active-low reset
//  start      : run request, honoured in IDLE/DONE only
//  cmp        : master modport (op_a/op_b out, dut_gt/dut_lt/dut_eq in)
//  busy       : run in progress
//  done       : run complete
//  pass       : done with zero mismatches
//  err_count  : mismatching vectors (saturating)
//  vec_count  : vectors checked
// Build option: CMP_CORNER_VECTORS_EN forces (0,0),(max,0),(0,max) as the first three vectors.
module cmp_stim_checker
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'h00A5,
  parameter int unsigned LAT         = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  cmp_stim_checker_if.master   cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     vec_count
);

  localparam int unsigned L = 2 * WIDTH;

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_DRIVE = 3'(ST_DRIVE);
  localparam logic [2:0] S_WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] S_CHECK = 3'(ST_CHECK);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);

  localparam logic [CNT_W-1:0] NUM_VEC_L = CNT_W'(NUM_VECTORS);
  localparam logic [1:0]       LAT_L     = 2'(LAT);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]       exp_q, exp_d;
  logic [1:0]       wait_q, wait_d;
  logic [CNT_W-1:0] err_q, err_d, vec_q, vec_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic             lfsr_load, lfsr_step;
  logic [L-1:0]     lfsr_val;
  logic [WIDTH-1:0] va, vb;
  logic             mism;
  logic [CNT_W-1:0] err_next, vec_next;

  cmp_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .value_o (lfsr_val)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    exp_d     = exp_q;
    wait_d    = wait_q;
    err_d     = err_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    va        = lfsr_val[L-1:WIDTH];
    vb        = lfsr_val[WIDTH-1:0];
    mism      = ({cmp.dut_gt, cmp.dut_lt, cmp.dut_eq} != exp_q);
    err_next  = (mism && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    vec_next  = vec_q + CNT_W'(1);

`ifdef CMP_CORNER_VECTORS_EN
    // vec_q equals the index of the vector being driven.
    if (vec_q == CNT_W'(0)) begin
      va = '0; vb = '0;
    end else if (vec_q == CNT_W'(1)) begin
      va = '1; vb = '0;
    end else if (vec_q == CNT_W'(2)) begin
      va = '0; vb = '1;
    end
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_DRIVE;
          err_d     = '0;
          vec_d     = '0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        op_a_d  = va;
        op_b_d  = vb;
        exp_d   = exp_flags(MAX_OP_W'(va), MAX_OP_W'(vb));
        wait_d  = '0;
        state_d = (LAT_L == 2'd0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LAT_L - 2'd1) state_d = S_CHECK;
        else                        wait_d  = wait_q + 2'd1;
      end
      S_CHECK: begin
        err_d = err_next;
        vec_d = vec_next;
`ifdef CMP_CORNER_VECTORS_EN
        lfsr_step = (vec_q >= CNT_W'(3));
`else
        lfsr_step = 1'b1;
`endif
        if (vec_next < NUM_VEC_L) begin
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      exp_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      exp_q   <= exp_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign cmp.op_a  = op_a_q;
  assign cmp.op_b  = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_cmp_stim_checker.sv
// Bench for cmp_stim_checker: LAT=0 and LAT=2 instances driven against behavioural
// comparators (golden, stuck flags, delayed by a register pipeline).
module tb_cmp_stim_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start2;
  int   mode0;        // 0 golden, 1 flags 000, 2 flags 111
  int   mode2;        // 2 = golden behind 2 regs, 3 = behind 3 regs
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cmp_stim_checker_if #(.WIDTH(4)) if0 ();
  cmp_stim_checker_if #(.WIDTH(4)) if2 ();

  logic       busy0, done0, pass0, busy2, done2, pass2;
  logic [7:0] err0, vec0, err2, vec2;

  cmp_stim_checker #(.WIDTH(4), .NUM_VECTORS(16), .SEED(16'h00A5), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmp(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0));

  cmp_stim_checker #(.WIDTH(4), .NUM_VECTORS(16), .SEED(16'h00A5), .LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmp(if2.master),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2));

  // Behavioural comparators.
  logic [2:0] gold0, gold2, p1, p2, p3;
  assign gold0 = {if0.op_a > if0.op_b, if0.op_a < if0.op_b, if0.op_a == if0.op_b};
  assign gold2 = {if2.op_a > if2.op_b, if2.op_a < if2.op_b, if2.op_a == if2.op_b};
  assign {if0.dut_gt, if0.dut_lt, if0.dut_eq} =
      (mode0 == 1) ? 3'b000 : (mode0 == 2) ? 3'b111 : gold0;
  always @(posedge clk) begin
    p1 <= gold2;
    p2 <= p1;
    p3 <= p2;
  end
  assign {if2.dut_gt, if2.dut_lt, if2.dut_eq} = (mode2 == 3) ? p3 : p2;

  // Expected {op_a,op_b} of vector k: seed, then successive Galois steps of x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] exp_vec(input int k);
    logic [7:0] v;
    int steps;
    v = 8'hA5;
    steps = k;
`ifdef CMP_CORNER_VECTORS_EN
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hF0;
    if (k == 2) return 8'h0F;
    steps = k - 3;
`endif
    for (int i = 0; i < steps; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    return v;
  endfunction

  // Observations from the last run_watch.
  logic [7:0] obs_ops [16];
  int         done_tick;
  int         busy_bad;

  // Start a run on the selected instance and record ops per vector, busy drops and done time.
  task automatic run_watch(input bit sel2, input bit spam);
    int p;
    p = sel2 ? 4 : 2;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (sel2) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    done_tick = -1;
    busy_bad  = 0;
    for (int t = 0; t <= 16 * p + 1; t++) begin
      if (t >= 1 && ((t - 1) % p) == 0 && ((t - 1) / p) < 16)
        obs_ops[(t - 1) / p] = sel2 ? {if2.op_a, if2.op_b} : {if0.op_a, if0.op_b};
      if (t < 16 * p && !(sel2 ? busy2 : busy0)) busy_bad++;
      if ((sel2 ? done2 : done0) && done_tick < 0) done_tick = t;
      if (spam && t < 16 * p) begin
        if (sel2) start2 = 1'($urandom_range(0, 1)); else start0 = 1'($urandom_range(0, 1));
      end else begin
        start0 = 1'b0;
        start2 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({if0.op_a, if0.op_b} !== 8'h00) begin n_fail++; $display("FAIL reset_ops0 got %h want 00", {if0.op_a, if0.op_b}); end
    n_vec++; if ({busy0, done0, pass0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0 got %b want 000", {busy0, done0, pass0}); end
    n_vec++; if ({err0, vec0} !== 16'h0000) begin n_fail++; $display("FAIL reset_counts0 got %h want 0000", {err0, vec0}); end
    n_vec++; if ({if2.op_a, if2.op_b, busy2, done2, pass2, err2, vec2} !== 27'd0) begin n_fail++; $display("FAIL reset_all2 got nonzero"); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden_lat0();
    mode0 = 0;
    run_watch(1'b0, 1'b0);
    n_vec++; if (obs_ops[0] !== exp_vec(0)) begin n_fail++; $display("FAIL first_op got %h want %h", obs_ops[0], exp_vec(0)); end
    for (int k = 1; k < 16; k++) begin
      n_vec++; if (obs_ops[k] !== exp_vec(k)) begin n_fail++; $display("FAIL op_seq[%0d] got %h want %h", k, obs_ops[k], exp_vec(k)); end
    end
    n_vec++; if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_hold got %0d drops want 0", busy_bad); end
    n_vec++; if (done_tick !== 32) begin n_fail++; $display("FAIL done_time got %0d want 32", done_tick); end
    n_vec++; if (vec0 !== 8'd16) begin n_fail++; $display("FAIL vec_count got %0d want 16", vec0); end
    n_vec++; if (err0 !== 8'd0) begin n_fail++; $display("FAIL err_golden got %0d want 0", err0); end
    n_vec++; if ({busy0, pass0} !== 2'b01) begin n_fail++; $display("FAIL pass_golden got busy/pass %b want 01", {busy0, pass0}); end
    n_vec++; if ({if0.op_a, if0.op_b} !== exp_vec(15)) begin n_fail++; $display("FAIL ops_held got %h want %h", {if0.op_a, if0.op_b}, exp_vec(15)); end
  endtask

  task automatic test_tied_flags();
    for (int m = 1; m <= 2; m++) begin
      mode0 = m;
      run_watch(1'b0, 1'b0);
      n_vec++; if (err0 !== 8'd16) begin n_fail++; $display("FAIL tied_err[%0d] got %0d want 16", m, err0); end
      n_vec++; if ({done0, pass0} !== 2'b10) begin n_fail++; $display("FAIL tied_pass[%0d] got done/pass %b want 10", m, {done0, pass0}); end
      n_vec++; if (vec0 !== 8'd16) begin n_fail++; $display("FAIL tied_vec[%0d] got %0d want 16", m, vec0); end
    end
    mode0 = 0;
  endtask

  task automatic test_lat2();
    mode2 = 3;
    run_watch(1'b1, 1'b0);
    n_vec++; if (!(err2 > 8'd0)) begin n_fail++; $display("FAIL lat3_err got %0d want >0", err2); end
    n_vec++; if (pass2 !== 1'b0) begin n_fail++; $display("FAIL lat3_pass got %b want 0", pass2); end
    mode2 = 2;
    run_watch(1'b1, 1'b0);
    n_vec++; if ({err2, pass2} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL lat2_pass got err %0d pass %b want 0/1", err2, pass2); end
    n_vec++; if (done_tick !== 64) begin n_fail++; $display("FAIL lat2_done_time got %0d want 64", done_tick); end
    n_vec++; if (vec2 !== 8'd16) begin n_fail++; $display("FAIL lat2_vec got %0d want 16", vec2); end
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (obs_ops[k] !== exp_vec(k)) begin n_fail++; $display("FAIL lat2_op[%0d] got %h want %h", k, obs_ops[k], exp_vec(k)); end
    end
  endtask

  task automatic test_reset_mid_run();
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (11) @(negedge clk);   // vector 5 on the outputs
    n_vec++; if ({if0.op_a, if0.op_b} !== exp_vec(5)) begin n_fail++; $display("FAIL mid_op5 got %h want %h", {if0.op_a, if0.op_b}, exp_vec(5)); end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({busy0, vec0, if0.op_a, if0.op_b} !== 17'd0) begin n_fail++; $display("FAIL mid_abort got busy %b vec %0d ops %h", busy0, vec0, {if0.op_a, if0.op_b}); end
    rst_n = 1'b1;
    run_watch(1'b0, 1'b0);
    n_vec++; if (obs_ops[0] !== exp_vec(0)) begin n_fail++; $display("FAIL replay_first got %h want %h", obs_ops[0], exp_vec(0)); end
    n_vec++; if (done_tick !== 32 || pass0 !== 1'b1) begin n_fail++; $display("FAIL replay_run got done_time %0d pass %b want 32/1", done_tick, pass0); end
  endtask

  task automatic test_back_to_back();
    mode0 = 0;
    run_watch(1'b0, 1'b1);
    n_vec++; if (vec0 !== 8'd16) begin n_fail++; $display("FAIL spam_vec got %0d want 16", vec0); end
    n_vec++; if (done_tick !== 32) begin n_fail++; $display("FAIL spam_done_time got %0d want 32", done_tick); end
    n_vec++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL spam_pass got %b want 1", pass0); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (obs_ops[k] !== exp_vec(k)) begin n_fail++; $display("FAIL spam_op[%0d] got %h want %h", k, obs_ops[k], exp_vec(k)); end
    end
    // start held high in DONE restarts immediately
    start0 = 1'b1;
    @(negedge clk);
    n_vec++; if ({busy0, done0, pass0, vec0} !== {3'b100, 8'd0}) begin n_fail++; $display("FAIL restart got busy/done/pass %b vec %0d want 100/0", {busy0, done0, pass0}, vec0); end
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++; if ({done0, pass0, vec0} !== {2'b11, 8'd16}) begin n_fail++; $display("FAIL restart_end got done/pass %b vec %0d want 11/16", {done0, pass0}, vec0); end
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    mode0  = 0;
    mode2  = 2;
    @(negedge clk);
    test_reset();
    test_golden_lat0();
    test_tied_flags();
    test_lat2();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
